// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice.
//   - ALU op-code values driven on alu_control
//   - arbiter FSM state encoding
//   - bit positions of the N/Z/C/V flags inside the 4-bit flag vectors
// No ports; imported by alu_arbiter and alu_rr_arb.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] OP_ZERO = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_AND  = 3'd3;
   localparam logic [2:0] OP_OR   = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_SHL  = 3'd6;
   localparam logic [2:0] OP_ONE  = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_rr_arb.sv
// ---------------------------------------------------------------------------
// alu_rr_arb
// Two-way grant selection for the shared ALU.
// Default build: round-robin. When both ports request, the port that did not
// win last time is granted; last_grant resets to 1 so port 0 wins first.
// With ALU_ARB_PRIO_EN defined: fixed priority, port 0 always wins and the
// last_grant history is not kept.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   valid0/valid1  request pending on port 0 / port 1
//   take           a grant is being consumed this cycle (updates history)
//   gnt            granted port index (only meaningful when a valid is high)
// ---------------------------------------------------------------------------
module alu_rr_arb
   import alu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic valid0,
   input  logic valid1,
   input  logic take,
   output logic gnt
);

`ifdef ALU_ARB_PRIO_EN

   // Port 1 is chosen only when port 0 is idle.
   assign gnt = ~valid0;

`else

   logic last_q;

   always_comb begin
      gnt = 1'b0;
      if (valid0 && valid1) begin
         gnt = ~last_q;
      end else if (valid1) begin
         gnt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= 1'b1;
      end else if (take) begin
         last_q <= gnt;
      end
   end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between two requesters.
// Flow: IDLE (grant + latch operands) -> EXEC (ALU settles, capture result)
//       -> RESP (hold response until the granted port accepts it).
// Build option: ALU_ARB_PRIO_EN selects fixed priority (port 0) instead of
// round-robin arbitration.
// Parameters: DATA_W (must be 32, the ALU width), CNT_W (completion counters)
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   reqN_valid/ready             command handshake, port N
//   reqN_op/a/b/shamt            command payload, port N
//   rspN_valid/ready             response handshake, port N
//   rsp_data, rsp_flags          captured result and {n,z,c,v} (shared)
//   alu_a/b/control/shamt        registered ALU inputs
//   alu_out, alu_n/z/c/v         ALU result and flags
//   nzcv                         flags of the most recent completed op
//   cnt0, cnt1                   saturating completed-op counters
//   busy                         high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [2:0]        req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [2:0]        req0_shamt,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [2:0]        req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [2:0]        req1_shamt,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [3:0]        rsp_flags,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_control,
   output logic [2:0]        alu_shamt,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_n,
   input  logic              alu_z,
   input  logic              alu_c,
   input  logic              alu_v,
   output logic [3:0]        nzcv,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1,
   output logic              busy
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   state_e            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [2:0]        alu_ctl_q, alu_ctl_d;
   logic [2:0]        alu_sh_q, alu_sh_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [3:0]        rsp_flags_q, rsp_flags_d;
   logic [3:0]        nzcv_q, nzcv_d;
   logic [CNT_W-1:0]  cnt0_q, cnt0_d;
   logic [CNT_W-1:0]  cnt1_q, cnt1_d;

   logic              arb_gnt;
   logic              take;
   logic              rsp_hs;
   logic [3:0]        alu_flags;

   assign alu_flags[FLAG_N] = alu_n;
   assign alu_flags[FLAG_Z] = alu_z;
   assign alu_flags[FLAG_C] = alu_c;
   assign alu_flags[FLAG_V] = alu_v;

   // The arbiter always points at a valid port when any port is valid, so a
   // handshake happens whenever IDLE sees at least one request.
   assign take = (state_q == IDLE) && (req0_valid || req1_valid);

   alu_rr_arb u_arb (
      .clk    (clk),
      .rst    (rst),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .take   (take),
      .gnt    (arb_gnt)
   );

   assign req0_ready = (state_q == IDLE) && req0_valid && !arb_gnt;
   assign req1_ready = (state_q == IDLE) && req1_valid &&  arb_gnt;

   assign rsp0_valid = (state_q == RESP) && !gnt_q;
   assign rsp1_valid = (state_q == RESP) &&  gnt_q;
   assign rsp_hs     = gnt_q ? rsp1_ready : rsp0_ready;

   assign busy        = (state_q != IDLE);
   assign rsp_data    = rsp_data_q;
   assign rsp_flags   = rsp_flags_q;
   assign nzcv        = nzcv_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_control = alu_ctl_q;
   assign alu_shamt   = alu_sh_q;
   assign cnt0        = cnt0_q;
   assign cnt1        = cnt1_q;

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_ctl_d   = alu_ctl_q;
      alu_sh_d    = alu_sh_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      nzcv_d      = nzcv_q;
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;

      case (state_q)
         IDLE: begin
            if (take) begin
               gnt_d     = arb_gnt;
               alu_a_d   = arb_gnt ? req1_a     : req0_a;
               alu_b_d   = arb_gnt ? req1_b     : req0_b;
               alu_ctl_d = arb_gnt ? req1_op    : req0_op;
               alu_sh_d  = arb_gnt ? req1_shamt : req0_shamt;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d  = alu_out;
            rsp_flags_d = alu_flags;
            nzcv_d      = alu_flags;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_hs) begin
               if (gnt_q) begin
                  if (cnt1_q != CntMax) cnt1_d = cnt1_q + CNT_W'(1);
               end else begin
                  if (cnt0_q != CntMax) cnt0_d = cnt0_q + CNT_W'(1);
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         gnt_q       <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctl_q   <= '0;
         alu_sh_q    <= '0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
         nzcv_q      <= '0;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_ctl_q   <= alu_ctl_d;
         alu_sh_q    <= alu_sh_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         nzcv_q      <= nzcv_d;
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
      end
   end

endmodule
